stream_mux_arb: RTL and testbench
=================================

Name: stream_mux_arb

Overview:
- Parametrised N-channel successor to the fixed-width combinational muxes: selects one of N_CH valid/ready input streams and forwards it through a single registered output stage.
- Arbitration is fixed-priority or round-robin, with optional packet lock so multi-beat transfers are never interleaved.
- Sits between multiple requesters (fetch, LSU, debug) and a shared bus/memory port in the core datapath.

Parameters:
- WIDTH, 32, data bits per channel
- N_CH, 4, number of input channels (>=1)
- RR_MODE, 1, 0 = fixed priority (channel 0 highest), 1 = round-robin
- LOCK_EN, 1, 1 = hold grant until the beat with i_last=1 is accepted; 0 = re-arbitrate every beat
- CH_W, (N_CH>1 ? $clog2(N_CH) : 1), derived channel-index width (localparam)

Ports:
- i_clk  in  1  clock, all logic rising-edge
- i_rst  in  1  synchronous, active-high reset
- i_data  in  N_CH*WIDTH  packed channel data, channel k at [k*WIDTH +: WIDTH]
- i_valid  in  N_CH  per-channel valid
- i_last  in  N_CH  per-channel end-of-packet flag
- o_ready  out  N_CH  per-channel ready (combinational)
- o_data  out  WIDTH  registered output data
- o_valid  out  1  registered output valid
- o_last  out  1  registered last flag of the held beat
- o_ch  out  CH_W  index of the channel that supplied the held beat
- i_ready  in  1  downstream ready

Behaviour:
- Reset: o_valid=0, o_data=0, o_last=0, o_ch=0; lock cleared; RR pointer = N_CH-1, so channel 0 has highest priority first.
- Reset mid-packet drops the lock and the held beat with no partial output.
- load_en = !o_valid || i_ready. One input beat is accepted per cycle at most. Latency is 1 cycle from acceptance to o_valid.
- Eligible set:
  - If locked: only the locked channel.
  - Otherwise: all k with i_valid[k]=1.
- Winner:
  - RR_MODE=0: lowest eligible index.
  - RR_MODE=1: first eligible index scanning from (ptr+1) mod N_CH upward, with wrap.
- o_ready[k] = load_en && (k == winner) && eligible-set nonempty. o_ready depends combinationally on i_valid and i_ready. Upstream must not make i_valid depend on o_ready.
- On accept (i_valid[w] && o_ready[w]):
  - o_data<=i_data[w], o_last<=i_last[w], o_ch<=w, o_valid<=1.
  - RR pointer<=w.
- If load_en=1 and no channel is eligible: o_valid<=0, and o_data/o_last/o_ch hold their previous values.
- Hold: o_valid=1 && i_ready=0 means all outputs stay stable and all o_ready are 0.
- Simultaneous downstream consume and new accept in the same cycle is required; full throughput is 1 beat/cycle.
- Lock (LOCK_EN=1):
  - Set on accept with i_last=0, with lock channel=w.
  - Cleared on accept with i_last=1.
  - While locked, other channels' valids are ignored even if the locked channel idles.
  - With LOCK_EN=0, i_last is still forwarded but never locks.
- RR pointer advances only on accept. With RR_MODE=0 the pointer is unused.
- N_CH=1: degenerates to a 1-entry pipeline register, and o_ch is constantly 0.

Decomposition:
- Shared package: none required. Module-local localparam CH_W.
- One sub-module: rr_arbiter (N_CH, RR_MODE params).
  - Inputs: request vector, pointer.
  - Output: one-hot grant plus binary index, purely combinational, reusable elsewhere.
- stream_mux_arb owns the lock, the pointer and the output register.

Test Plan:
- Reset and single beat: assert i_rst 2 cycles; then i_valid=4'b0100, i_data ch2=32'hDEAD_BEEF, i_last=1, i_ready=1 -> o_ready=4'b0100 in that cycle; next cycle o_valid=1, o_data=32'hDEAD_BEEF, o_ch=2, o_last=1.
- Round-robin fairness: RR_MODE=1, all four valid every cycle with i_last=1, i_ready=1 -> grants 0,1,2,3,0,1 on consecutive cycles, one beat per cycle with no bubbles.
- Fixed priority: RR_MODE=0, i_valid=4'b1010 held for 4 cycles -> ch1 granted every cycle and ch3 never.
- Backpressure: o_valid=1 with i_ready=0 for 3 cycles while i_valid=4'b1111 -> o_ready=0, o_data/o_ch stable; i_ready=1 on cycle 4 -> next beat accepted the same cycle.
- Packet lock: LOCK_EN=1; ch1 sends 3 beats (last on the 3rd) with a 1-cycle gap after beat 1, ch0 valid throughout -> o_ch=1,1,1 with ch0 stalled during the gap; ch0 granted after ch1's last beat.
- Reset mid-packet: lock on ch2 after beat 1, i_rst pulsed -> o_valid=0, lock cleared; next grant goes to ch0 when i_valid=4'b0101.

Source files
------------

// File: rtl/stream_mux_arb_pkg.sv
// Shared helpers for the stream_mux_arb slice: channel-index arithmetic
// used by the arbiter scan.
package stream_mux_arb_pkg;

  function automatic int wrap_add(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/stream_mux_arb_rr_arbiter.sv
// Combinational arbiter: fixed-priority (lowest index) or round-robin scan
// starting just after the pointer. Produces a one-hot grant plus its index.
module rr_arbiter
  import stream_mux_arb_pkg::*;
#(
  parameter  int N_CH    = 4,
  parameter  int RR_MODE = 1,
  localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic [N_CH-1:0] req_i,
  input  logic [CH_W-1:0] ptr_i,
  output logic [N_CH-1:0] gnt_o,
  output logic [CH_W-1:0] idx_o,
  output logic            any_o
);

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int i = 1; i <= N_CH; i++) begin
      logic [CH_W-1:0] k;
      k = (RR_MODE != 0) ? CH_W'(wrap_add(32'(ptr_i), i, N_CH)) : CH_W'(i - 1);
      if (!any_o && req_i[k]) begin
        any_o    = 1'b1;
        gnt_o[k] = 1'b1;
        idx_o    = k;
      end
    end
  end

endmodule

// File: rtl/stream_mux_arb.sv
// N-channel valid/ready stream mux with registered output stage, fixed or
// round-robin arbitration and optional packet lock against interleaving.
module stream_mux_arb
  import stream_mux_arb_pkg::*;
#(
  parameter  int WIDTH   = 32,
  parameter  int N_CH    = 4,
  parameter  int RR_MODE = 1,
  parameter  int LOCK_EN = 1,
  localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [N_CH*WIDTH-1:0] i_data,
  input  logic [N_CH-1:0]       i_valid,
  input  logic [N_CH-1:0]       i_last,
  output logic [N_CH-1:0]       o_ready,
  output logic [WIDTH-1:0]      o_data,
  output logic                  o_valid,
  output logic                  o_last,
  output logic [CH_W-1:0]       o_ch,
  input  logic                  i_ready
);

  logic [WIDTH-1:0] ch_data [N_CH];

  for (genvar g = 0; g < N_CH; g++) begin : g_unpack
    assign ch_data[g] = i_data[g*WIDTH +: WIDTH];
  end

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic [CH_W-1:0]  ptr_q, ptr_d;
  logic             lock_q, lock_d;
  logic [CH_W-1:0]  lock_ch_q, lock_ch_d;

  logic [N_CH-1:0] elig;
  logic [N_CH-1:0] gnt;
  logic [CH_W-1:0] win;
  logic            any_elig;
  logic            load_en;
  logic            accept;

  // While locked only the locked channel may compete, even if it idles.
  assign elig    = lock_q ? (i_valid & (N_CH'(1) << lock_ch_q)) : i_valid;
  assign load_en = !valid_q || i_ready;
  assign accept  = load_en && any_elig;
  assign o_ready = accept ? gnt : '0;

  rr_arbiter #(
    .N_CH    (N_CH),
    .RR_MODE (RR_MODE)
  ) u_arb (
    .req_i (elig),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (win),
    .any_o (any_elig)
  );

  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    last_d    = last_q;
    ch_d      = ch_q;
    ptr_d     = ptr_q;
    lock_d    = lock_q;
    lock_ch_d = lock_ch_q;
    if (accept) begin
      data_d  = ch_data[win];
      last_d  = i_last[win];
      ch_d    = win;
      valid_d = 1'b1;
      ptr_d   = win;
      if (LOCK_EN != 0) begin
        lock_d    = !i_last[win];
        lock_ch_d = win;
      end
    end else if (load_en) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      ch_q      <= '0;
      ptr_q     <= CH_W'(N_CH - 1);
      lock_q    <= 1'b0;
      lock_ch_q <= '0;
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      ch_q      <= ch_d;
      ptr_q     <= ptr_d;
      lock_q    <= lock_d;
      lock_ch_q <= lock_ch_d;
    end
  end

  assign o_data  = data_q;
  assign o_valid = valid_q;
  assign o_last  = last_q;
  assign o_ch    = ch_q;

endmodule

// File: tb/tb_stream_mux_arb.sv
// Bench for stream_mux_arb: two instances (round-robin+lock, fixed-priority
// without lock) share stimulus and are compared each cycle to a reference model.
module tb_stream_mux_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] chd [4];
  logic [127:0] data;
  logic [3:0]  valid;
  logic [3:0]  last;
  logic        ready;

  logic [3:0]  rdy [2];
  logic [31:0] od  [2];
  logic        ov  [2];
  logic        ol  [2];
  logic [1:0]  och [2];

  int n_cmp  = 0;
  int n_fail = 0;

  assign data = {chd[3], chd[2], chd[1], chd[0]};

  always #5 clk = ~clk;

  stream_mux_arb #(.WIDTH(32), .N_CH(4), .RR_MODE(1), .LOCK_EN(1)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_data(data), .i_valid(valid), .i_last(last),
    .o_ready(rdy[0]), .o_data(od[0]), .o_valid(ov[0]), .o_last(ol[0]),
    .o_ch(och[0]), .i_ready(ready)
  );

  stream_mux_arb #(.WIDTH(32), .N_CH(4), .RR_MODE(0), .LOCK_EN(0)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_data(data), .i_valid(valid), .i_last(last),
    .o_ready(rdy[1]), .o_data(od[1]), .o_valid(ov[1]), .o_last(ol[1]),
    .o_ch(och[1]), .i_ready(ready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: instance 0 is round-robin with lock, instance 1 fixed priority.
  logic        mv  [2] = '{1'b0, 1'b0};
  logic [31:0] md  [2] = '{32'd0, 32'd0};
  logic        ml  [2] = '{1'b0, 1'b0};
  int          mch [2] = '{0, 0};
  int          mptr[2] = '{3, 3};
  logic        mlk [2] = '{1'b0, 1'b0};
  int          mlch[2] = '{0, 0};

  function automatic int pick(input logic [3:0] el, input int ptr, input bit rr);
    for (int i = 1; i <= 4; i++) begin
      int k;
      k = rr ? (ptr + i) % 4 : i - 1;
      if (el[k]) return k;
    end
    return -1;
  endfunction

  // Inputs change just after posedge, so at negedge they are what the next edge samples.
  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      logic [3:0] el;
      logic [3:0] er;
      bit         loaden;
      int         w;
      chk($sformatf("m%0d_o_valid", m), 32'(ov[m]), 32'(mv[m]));
      chk($sformatf("m%0d_o_data", m), od[m], md[m]);
      chk($sformatf("m%0d_o_last", m), 32'(ol[m]), 32'(ml[m]));
      chk($sformatf("m%0d_o_ch", m), 32'(och[m]), 32'(mch[m]));
      loaden = !mv[m] || ready;
      el = 4'b0000;
      for (int k = 0; k < 4; k++)
        el[k] = valid[k] && (!mlk[m] || mlch[m] == k);
      w  = pick(el, mptr[m], m == 0);
      er = 4'b0000;
      if (loaden && w >= 0) er[w] = 1'b1;
      chk($sformatf("m%0d_o_ready", m), 32'(rdy[m]), 32'(er));
      if (rst) begin
        mv[m] = 1'b0; md[m] = '0; ml[m] = 1'b0; mch[m] = 0;
        mptr[m] = 3; mlk[m] = 1'b0; mlch[m] = 0;
      end else if (loaden) begin
        if (w >= 0) begin
          mv[m] = 1'b1; md[m] = chd[w]; ml[m] = last[w]; mch[m] = w; mptr[m] = w;
          if (m == 0) begin
            mlk[m]  = !last[w];
            mlch[m] = w;
          end
        end else begin
          mv[m] = 1'b0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] hold_d;
  logic [1:0]  hold_ch;

  initial begin
    rst = 1'b1; valid = '0; last = '0; ready = 1'b1;
    for (int k = 0; k < 4; k++) chd[k] = '0;
    step(); step();
    rst = 1'b0;
    chk("rst_o_valid", 32'(ov[0]), 32'd0);
    chk("rst_o_data", od[0], 32'd0);
    chk("rst_o_ch", 32'(och[0]), 32'd0);
    chk("rst_o_last", 32'(ol[0]), 32'd0);

    // single beat on channel 2
    chd[2] = 32'hDEAD_BEEF; valid = 4'b0100; last = 4'b1111;
    #1 chk("single_ready", 32'(rdy[0]), 32'h4);
    step();
    chk("single_valid", 32'(ov[0]), 32'd1);
    chk("single_data", od[0], 32'hDEAD_BEEF);
    chk("single_ch", 32'(och[0]), 32'd2);
    chk("single_last", 32'(ol[0]), 32'd1);
    valid = '0; rst = 1'b1;
    step();
    rst = 1'b0;

    // round-robin fairness, no bubbles
    for (int k = 0; k < 4; k++) chd[k] = 32'h1000 + k;
    valid = 4'b1111; last = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      #1 chk("rr_ready", 32'(rdy[0]), 32'(1 << (i % 4)));
      step();
      chk("rr_ch", 32'(och[0]), 32'(i % 4));
      chk("rr_data", od[0], 32'h1000 + (i % 4));
    end

    // fixed priority: ch1 beats ch3 every cycle
    valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      #1 chk("fp_ready", 32'(rdy[1]), 32'h2);
      step();
      chk("fp_ch", 32'(och[1]), 32'd1);
    end

    // backpressure hold, then resume with simultaneous consume/accept
    valid = 4'b1111; ready = 1'b0;
    hold_d = od[0]; hold_ch = och[0];
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_ready", 32'(rdy[0]), 32'd0);
      step();
      chk("bp_data", od[0], hold_d);
      chk("bp_ch", 32'(och[0]), 32'(hold_ch));
      chk("bp_valid", 32'(ov[0]), 32'd1);
    end
    ready = 1'b1;
    #1 chk("bp_resume_ready", 32'(rdy[0]), 32'h4);
    step();
    chk("bp_resume_ch", 32'(och[0]), 32'd2);

    // packet lock on ch1 with a gap; ch0 must wait
    rst = 1'b1; valid = '0;
    step();
    rst = 1'b0;
    chd[1] = 32'hA1; valid = 4'b0010; last = 4'b0000;
    #1 chk("lock_b1_ready", 32'(rdy[0]), 32'h2);
    step();
    chk("lock_b1_ch", 32'(och[0]), 32'd1);
    chd[0] = 32'hB0; valid = 4'b0001; last = 4'b0001;
    #1 chk("lock_gap_ready", 32'(rdy[0]), 32'd0);
    step();
    chk("lock_gap_valid", 32'(ov[0]), 32'd0);
    chd[1] = 32'hA2; valid = 4'b0011;
    #1 chk("lock_b2_ready", 32'(rdy[0]), 32'h2);
    step();
    chk("lock_b2_data", od[0], 32'hA2);
    chd[1] = 32'hA3; last = 4'b0011;
    #1 chk("lock_b3_ready", 32'(rdy[0]), 32'h2);
    step();
    chk("lock_b3_last", 32'(ol[0]), 32'd1);
    valid = 4'b0001;
    #1 chk("lock_after_ready", 32'(rdy[0]), 32'h1);
    step();
    chk("lock_after_ch", 32'(och[0]), 32'd0);

    // reset mid-packet clears lock and output
    chd[2] = 32'hC1; valid = 4'b0100; last = 4'b0000;
    #1 chk("rmid_ready", 32'(rdy[0]), 32'h4);
    step();
    rst = 1'b1; valid = '0;
    step();
    chk("rmid_valid", 32'(ov[0]), 32'd0);
    rst = 1'b0; valid = 4'b0101; last = 4'b1111;
    #1 chk("rmid_next_ready", 32'(rdy[0]), 32'h1);
    step();
    chk("rmid_next_ch", 32'(och[0]), 32'd0);

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rst   = ($urandom_range(0, 199) == 0);
      valid = 4'($urandom);
      last  = 4'($urandom);
      ready = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < 4; k++) chd[k] = $urandom;
      step();
    end
    rst = 1'b0; valid = '0; ready = 1'b1;
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
